// File: rtl/chess_turn_ctrl.sv
// Two-player chess clock: counts down the player to move, switches on
// move buttons, supports pause/resume and flags the player whose time ran out.
//
// Ports:
//   clkIn   system clock
//   rstIn   async active-low reset
//   tickIn  time-base square wave; each rising edge is one sub-second tick
//   start   start a game from IDLE, or rearm from DONE (one-cycle pulse)
//   pause   toggle pause while a game runs (one-cycle pulse)
//   btnA/B  move-done pulses for player A / player B
//   minA/B  remaining minutes (0..99)
//   secA/B  remaining seconds (0..59)
//   runA/B  that player's clock is counting
//   flagA/B that player's time has expired
//   state   IDLE=0 RUN_A=1 RUN_B=2 PAUSE=3 DONE=4
module chess_turn_ctrl #(
  parameter int TICKS_PER_SEC = 100,
  parameter int INIT_MIN      = 5
) (
  input  logic       clkIn,
  input  logic       rstIn,
  input  logic       tickIn,
  input  logic       start,
  input  logic       pause,
  input  logic       btnA,
  input  logic       btnB,
  output logic [6:0] minA,
  output logic [6:0] minB,
  output logic [5:0] secA,
  output logic [5:0] secB,
  output logic       runA,
  output logic       runB,
  output logic       flagA,
  output logic       flagB,
  output logic [2:0] state
);

  localparam int SW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SW-1:0] SUB_MAX = SW'(TICKS_PER_SEC - 1);
  localparam logic [6:0] MIN0 = 7'(INIT_MIN);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN_A = 3'd1,
    RUN_B = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        st;
  state_t        saved;
  logic          tickQ;
  logic [SW-1:0] sub;

  logic       tickEdge;
  logic       wrap;
  logic       actBtn;
  logic [6:0] curMin;
  logic [5:0] curSec;
  logic [6:0] decMin;
  logic [5:0] decSec;
  logic       hitZero;

  assign tickEdge = tickIn & ~tickQ;
  assign wrap     = tickEdge && (sub == SUB_MAX);
  assign actBtn   = (st == RUN_A) ? btnA : btnB;
  assign curMin   = (st == RUN_B) ? minB : minA;
  assign curSec   = (st == RUN_B) ? secB : secA;

  // One-second decrement of the active clock; holds at 0:00.
  always_comb begin
    decMin = curMin;
    decSec = curSec;
    if (curSec != 6'd0) begin
      decSec = curSec - 6'd1;
    end else if (curMin != 7'd0) begin
      decSec = 6'd59;
      decMin = curMin - 7'd1;
    end
  end

  assign hitZero = (decMin == 7'd0) && (decSec == 6'd0);

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      st    <= IDLE;
      saved <= RUN_A;
      tickQ <= 1'b0;
      sub   <= '0;
      minA  <= MIN0;
      minB  <= MIN0;
      secA  <= 6'd0;
      secB  <= 6'd0;
      flagA <= 1'b0;
      flagB <= 1'b0;
    end else begin
      tickQ <= tickIn;
      unique case (st)
        IDLE: begin
          if (start) begin
            st  <= RUN_A;
            sub <= '0;
          end
        end
        RUN_A, RUN_B: begin
          if (wrap && hitZero) begin
            sub <= '0;
            st  <= DONE;
            if (st == RUN_A) begin
              minA  <= decMin;
              secA  <= decSec;
              flagA <= 1'b1;
            end else begin
              minB  <= decMin;
              secB  <= decSec;
              flagB <= 1'b1;
            end
          end else if (pause) begin
            saved <= st;
            st    <= PAUSE;
          end else if (actBtn) begin
            st  <= (st == RUN_A) ? RUN_B : RUN_A;
            sub <= '0;
          end else if (tickEdge) begin
            if (wrap) begin
              sub <= '0;
              if (st == RUN_A) begin
                minA <= decMin;
                secA <= decSec;
              end else begin
                minB <= decMin;
                secB <= decSec;
              end
            end else begin
              sub <= sub + 1'b1;
            end
          end
        end
        PAUSE: begin
          if (pause) st <= saved;
        end
        DONE: begin
          if (start) begin
            st    <= IDLE;
            sub   <= '0;
            minA  <= MIN0;
            minB  <= MIN0;
            secA  <= 6'd0;
            secB  <= 6'd0;
            flagA <= 1'b0;
            flagB <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign runA  = (st == RUN_A);
  assign runB  = (st == RUN_B);
  assign state = st;

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Bench for chess_turn_ctrl: directed scenarios plus random stimulus
// against a seconds-based reference model.
module tb_chess_turn_ctrl;

  localparam int TPS  = 4;
  localparam int IMIN = 1;

  logic       clkIn = 1'b0;
  logic       rstIn = 1'b0;
  logic       tickIn = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       btnA = 1'b0;
  logic       btnB = 1'b0;
  logic [6:0] minA, minB;
  logic [5:0] secA, secB;
  logic       runA, runB, flagA, flagB;
  logic [2:0] state;

  int cmp = 0;
  int bad = 0;

  // Reference model: remaining time kept as total seconds per player.
  int m_st;
  int m_saved;
  int m_sub;
  int m_rem [2];
  bit m_flag [2];
  bit m_prev;

  chess_turn_ctrl #(.TICKS_PER_SEC(TPS), .INIT_MIN(IMIN)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .tickIn(tickIn),
    .start(start), .pause(pause), .btnA(btnA), .btnB(btnB),
    .minA(minA), .minB(minB), .secA(secA), .secB(secB),
    .runA(runA), .runB(runB), .flagA(flagA), .flagB(flagB),
    .state(state)
  );

  always #5 clkIn = ~clkIn;

  task automatic model_reset();
    m_st = 0; m_saved = 1; m_sub = 0; m_prev = 0;
    m_rem[0] = IMIN * 60; m_rem[1] = IMIN * 60;
    m_flag[0] = 0; m_flag[1] = 0;
  endtask

  task automatic model_step(input bit s, p, a, b, t);
    bit te;
    int act;
    te = t && !m_prev;
    m_prev = t;
    case (m_st)
      0: if (s) begin m_st = 1; m_sub = 0; end
      1, 2: begin
        act = m_st - 1;
        if (te && m_sub == TPS - 1 && m_rem[act] == 1) begin
          m_rem[act] = 0; m_flag[act] = 1; m_st = 4; m_sub = 0;
        end else if (p) begin
          m_saved = m_st; m_st = 3;
        end else if ((act == 0) ? a : b) begin
          m_st = 3 - m_st; m_sub = 0;
        end else if (te) begin
          if (m_sub == TPS - 1) begin
            m_sub = 0;
            if (m_rem[act] > 0) m_rem[act]--;
          end else m_sub++;
        end
      end
      3: if (p) m_st = m_saved;
      4: if (s) model_reset();
      default: ;
    endcase
  endtask

  task automatic cyc(input bit s, p, a, b, t);
    @(negedge clkIn);
    start = s; pause = p; btnA = a; btnB = b; tickIn = t;
    model_step(s, p, a, b, t);
    @(posedge clkIn);
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clkIn);
    rstIn = 0; start = 0; pause = 0; btnA = 0; btnB = 0; tickIn = 0;
    model_reset();
    @(negedge clkIn);
    rstIn = 1;
  endtask

  task automatic test_reset();
    @(negedge clkIn);
    rstIn = 0;
    #1;
    cmp++;
    if ({state, minA, secA, minB, secB, runA, runB, flagA, flagB} !==
        {3'd0, 7'd1, 6'd0, 7'd1, 6'd0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_state got st=%0d A=%0d:%0d B=%0d:%0d r=%b%b f=%b%b want 0 1:0 1:0 00 00",
               state, minA, secA, minB, secB, runA, runB, flagA, flagB);
    end
    model_reset();
    @(negedge clkIn);
    rstIn = 1;
  endtask

  task automatic test_countdown();
    cyc(1, 0, 0, 0, 0);
    edges(8);
    cmp++;
    if ({state, minA, secA, minB, secB, runA} !==
        {3'd1, 7'd0, 6'd58, 7'd1, 6'd0, 1'b1}) begin
      bad++;
      $display("FAIL countdown got st=%0d A=%0d:%0d B=%0d:%0d runA=%b want 1 0:58 1:0 1",
               state, minA, secA, minB, secB, runA);
    end
  endtask

  task automatic test_switch();
    edges(2);
    cyc(0, 0, 1, 0, 0);
    cmp++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL switch_state got %0d want 2", state);
    end
    cyc(0, 0, 1, 0, 0);
    cmp++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL inactive_btn got %0d want 2", state);
    end
    edges(4);
    cmp++;
    if ({minB, secB, minA, secA} !== {7'd0, 6'd59, 7'd0, 6'd58}) begin
      bad++;
      $display("FAIL switch_time got B=%0d:%0d A=%0d:%0d want B=0:59 A=0:58",
               minB, secB, minA, secA);
    end
  endtask

  task automatic test_pause();
    edges(3);
    cyc(0, 1, 0, 0, 0);
    edges(10);
    cmp++;
    if ({state, secB} !== {3'd3, 6'd59}) begin
      bad++;
      $display("FAIL paused got st=%0d secB=%0d want 3 59", state, secB);
    end
    cyc(0, 1, 0, 0, 0);
    edges(1);
    cmp++;
    if ({state, minB, secB} !== {3'd2, 7'd0, 6'd58}) begin
      bad++;
      $display("FAIL resume got st=%0d B=%0d:%0d want 2 0:58", state, minB, secB);
    end
  endtask

  task automatic test_priority();
    cyc(0, 0, 0, 1, 0);
    edges(3);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cmp++;
    if ({state, secA, secB} !== {3'd2, 6'd58, 6'd58}) begin
      bad++;
      $display("FAIL btn_vs_tick got st=%0d secA=%0d secB=%0d want 2 58 58",
               state, secA, secB);
    end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 1, 0, 0);
    cmp++;
    if (state !== 3'd3) begin
      bad++;
      $display("FAIL pause_vs_btn got %0d want 3", state);
    end
    cyc(0, 1, 0, 0, 0);
    cmp++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL recorded_run got %0d want 1", state);
    end
  endtask

  task automatic test_expiry();
    do_reset();
    cyc(1, 0, 0, 0, 0);
    edges(240);
    cmp++;
    if ({state, minA, secA, flagA, runA, minB, secB, flagB} !==
        {3'd4, 7'd0, 6'd0, 1'b1, 1'b0, 7'd1, 6'd0, 1'b0}) begin
      bad++;
      $display("FAIL expiry got st=%0d A=%0d:%0d fA=%b rA=%b B=%0d:%0d fB=%b",
               state, minA, secA, flagA, runA, minB, secB, flagB);
    end
    edges(3);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    cmp++;
    if ({state, minA, secA, flagA, minB, secB} !==
        {3'd4, 7'd0, 6'd0, 1'b1, 7'd1, 6'd0}) begin
      bad++;
      $display("FAIL done_hold got st=%0d A=%0d:%0d fA=%b B=%0d:%0d",
               state, minA, secA, flagA, minB, secB);
    end
    cyc(1, 0, 0, 0, 0);
    cmp++;
    if ({state, minA, secA, minB, secB, flagA, flagB} !==
        {3'd0, 7'd1, 6'd0, 7'd1, 6'd0, 2'b00}) begin
      bad++;
      $display("FAIL rearm got st=%0d A=%0d:%0d B=%0d:%0d f=%b%b want 0 1:0 1:0 00",
               state, minA, secA, minB, secB, flagA, flagB);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 0, 0, 0);
    edges(5);
    cyc(0, 1, 0, 0, 0);
    @(posedge clkIn);
    #3;
    rstIn = 0;
    #1;
    cmp++;
    if ({state, minA, secA, minB, secB, runA, runB, flagA, flagB} !==
        {3'd0, 7'd1, 6'd0, 7'd1, 6'd0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_mid got st=%0d A=%0d:%0d B=%0d:%0d r=%b%b",
               state, minA, secA, minB, secB, runA, runB);
    end
    model_reset();
    @(negedge clkIn);
    rstIn = 1;
    cyc(1, 0, 0, 0, 0);
    cmp++;
    if ({state, minA, secA, runA} !== {3'd1, 7'd1, 6'd0, 1'b1}) begin
      bad++;
      $display("FAIL restart got st=%0d A=%0d:%0d runA=%b want 1 1:0 1",
               state, minA, secA, runA);
    end
  endtask

  task automatic test_random();
    logic [33:0] exp_v;
    logic [33:0] got_v;
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2,
          1'($urandom_range(0, 1)));
      exp_v = {3'(m_st), 7'(m_rem[0] / 60), 6'(m_rem[0] % 60),
               7'(m_rem[1] / 60), 6'(m_rem[1] % 60),
               m_st == 1, m_st == 2, m_flag[0], m_flag[1]};
      got_v = {state, minA, secA, minB, secB, runA, runB, flagA, flagB};
      cmp++;
      if (got_v !== exp_v) begin
        bad++;
        if (bad < 20)
          $display("FAIL random cyc=%0d got=%h want=%h", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_countdown();
    test_switch();
    test_pause();
    test_priority();
    test_expiry();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
